// File: rtl/seq_pkg.sv
// Package: seq_pkg
// Shared definitions for the consumer end of the one-hot sequencer bus:
// bus and instruction widths, instruction classes, the class-to-length
// mapping, the fetch strobe decode masks and the decoder FSM states.
package seq_pkg;

  localparam int NSTATES = 23;  // one-hot states A..W, state k is bit k-1
  localparam int IW      = 8;   // instruction width

  localparam logic [IW-1:0] OPC_HALT = 8'hAE;

  typedef logic [NSTATES-1:0] state_vec_t;

  typedef enum logic [2:0] {
    MOV8, SETAB, ALU, LDST, MOV16, INC16, GOTO, HALT
  } op_class_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } dec_state_t;

  typedef struct packed {
    logic sel_pc;
    logic mem_rd;
    logic ld_inst;
    logic ld_inc;
    logic ld_pc;
  } strobe_t;

  // Fetch strobe decode: bit k-1 set means the strobe is active in state k.
  localparam state_vec_t SEL_PC_MASK  = 23'h00003F;  // states 1..6
  localparam state_vec_t MEM_RD_MASK  = 23'h00000F;  // states 1..4
  localparam state_vec_t LD_INST_MASK = 23'h000004;  // state 3
  localparam state_vec_t LD_INC_MASK  = 23'h000030;  // states 5..6
  localparam state_vec_t LD_PC_MASK   = 23'h0000C0;  // states 7..8

  // Classify an instruction; the exact HALT opcode takes priority over the
  // 0x80..0xBF group it lives in.
  function automatic op_class_t op_decode(input logic [IW-1:0] ins);
    op_class_t op;
    if (ins == OPC_HALT) begin
      op = HALT;
    end else begin
      case (ins[7:6])
        2'b00:   op = MOV8;
        2'b01:   op = SETAB;
        2'b10: begin
          case (ins[5:4])
            2'b00:   op = ALU;
            2'b01:   op = LDST;
            2'b10:   op = MOV16;
            default: op = INC16;
          endcase
        end
        default: op = GOTO;
      endcase
    end
    return op;
  endfunction

  // Number of sequencer states the instruction occupies.
  function automatic int op_len(input op_class_t op);
    int len;
    len = 8;
    case (op)
      MOV8, SETAB, ALU: len = 8;
      HALT, MOV16:      len = 10;
      LDST:             len = 12;
      INC16:            len = 14;
      GOTO:             len = 24;
      default:          len = 8;
    endcase
    return len;
  endfunction

  // One-hot mask of the final state of the instruction. GOTO is longer than
  // the bus, so its bit shifts out and it never requests an abort.
  function automatic state_vec_t end_mask(input op_class_t op);
    return state_vec_t'(1) << (op_len(op) - 1);
  endfunction

endpackage

// File: rtl/seq_onehot_chk.sv
// Module: seq_onehot_chk
// Protocol checker for the one-hot sequencer bus. Flags a multi-hot bus or
// an illegal successor (state k may only be followed by k+1, by state 1, or
// by idle). The flag is sticky until reset.
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-high reset
//   fsm_out  in   one-hot sequencer state bus
//   err      out  registered sticky error flag
//   err_set  out  combinational: a violation is being sampled this cycle
module seq_onehot_chk
  import seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  state_vec_t fsm_out,
  output logic       err,
  output logic       err_set
);

  state_vec_t prev_q;
  state_vec_t allowed;
  logic       multi_hot;
  logic       bad_succ;

  always_comb begin
    // Successor of state k is bit k (state k+1) or bit 0 (wrap to state 1);
    // state W's successor bit falls off the top, leaving only the wrap.
    allowed   = {prev_q[NSTATES-2:0], 1'b1};
    multi_hot = ($countones(fsm_out) > 1);
    bad_succ  = (|prev_q) && (|fsm_out) && (|(fsm_out & ~allowed));
    err_set   = multi_hot || bad_succ;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= '0;
      err    <= 1'b0;
    end else begin
      prev_q <= fsm_out;
      err    <= err | err_set;
    end
  end

endmodule

// File: rtl/fsa_decoder.sv
// Module: fsa_decoder
// Consumer end of the 23-state one-hot sequencer bus. Latches the fetched
// instruction in state 3, classifies it, returns a one-cycle abort after the
// instruction's final state, and decodes the bus into registered fetch
// strobes. A HALT instruction parks the block (abort held, strobes off)
// until a resume pulse.
// Optional build macro: FSA_DEC_ONEHOT_CHK_EN adds the one-hot protocol
// checker; a detected error drives err and parks the block as if halted.
// Ports:
//   clock     in   system clock
//   reset     in   synchronous, active-high reset
//   fsm_out   in   one-hot sequencer state (all-zero = idle)
//   data_bus  in   memory data, sampled as the instruction in state 3
//   resume    in   pulse that leaves the halted state
//   abort     out  request to the sequencer to end the current instruction
//   sel_pc    out  drive PC onto the address bus
//   mem_rd    out  memory read strobe
//   ld_inst   out  instruction register load strobe
//   ld_inc    out  load incrementer from the address bus
//   ld_pc     out  load PC from the incrementer
//   instr_q   out  latched instruction
//   halted    out  HALT executed (or protocol error); sequencer must hold
//   err       out  sticky protocol error (0 unless the checker is built)
// All outputs are registered from the bus value sampled on the previous edge.
module fsa_decoder
  import seq_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  state_vec_t    fsm_out,
  input  logic [IW-1:0] data_bus,
  input  logic          resume,
  output logic          abort,
  output logic          sel_pc,
  output logic          mem_rd,
  output logic          ld_inst,
  output logic          ld_inc,
  output logic          ld_pc,
  output logic [IW-1:0] instr_q,
  output logic          halted,
  output logic          err
);

  dec_state_t    st_q, st_d;
  strobe_t       strobe_q, strobe_d;
  logic          abort_d;
  logic          halted_d;
  logic [IW-1:0] instr_d;
  logic          inst_vld, inst_vld_d;  // an instruction was fetched since reset
  logic          err_any;
  logic          hold;
  logic          end_hit;
  op_class_t     cls;

`ifdef FSA_DEC_ONEHOT_CHK_EN
  logic err_set;

  seq_onehot_chk u_chk (
    .clock   (clock),
    .reset   (reset),
    .fsm_out (fsm_out),
    .err     (err),
    .err_set (err_set)
  );

  // A violation sampled now parks the block on this very edge.
  assign err_any = err | err_set;
`else
  assign err     = 1'b0;
  assign err_any = 1'b0;
`endif

  assign cls     = op_decode(instr_q);
  assign end_hit = |(fsm_out & end_mask(cls));
  assign hold    = (st_q == ST_HALTED) || err_any;

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    st_d       = st_q;
    strobe_d   = '0;
    abort_d    = 1'b0;
    instr_d    = instr_q;
    inst_vld_d = inst_vld;

    if (hold) begin
      // Parked: abort stays asserted, strobes stay off, instruction frozen.
      abort_d = 1'b1;
      if ((st_q == ST_HALTED) && resume && !err_any) begin
        st_d    = ST_RUN;
        abort_d = 1'b0;
      end
    end else begin
      // Multi-hot bus values decode as the OR of their states.
      strobe_d.sel_pc  = |(fsm_out & SEL_PC_MASK);
      strobe_d.mem_rd  = |(fsm_out & MEM_RD_MASK);
      strobe_d.ld_inst = |(fsm_out & LD_INST_MASK);
      strobe_d.ld_inc  = |(fsm_out & LD_INC_MASK);
      strobe_d.ld_pc   = |(fsm_out & LD_PC_MASK);

      // The class uses the instruction latched by an earlier state 3; a
      // reset discards it, so nothing aborts until the next fetch.
      if (inst_vld && end_hit) begin
        abort_d = 1'b1;
        if (cls == HALT) begin
          st_d     = ST_HALTED;
          strobe_d = '0;
        end
      end

      if (fsm_out[2]) begin
        instr_d    = data_bus;
        inst_vld_d = 1'b1;
      end
    end

    halted_d = (st_d == ST_HALTED) || err_any;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: instr_q is reset as well, since a reset must discard any
      // instruction caught mid-flight and present a known 8'h00.
      st_q     <= ST_RUN;
      strobe_q <= '0;
      abort    <= 1'b0;
      halted   <= 1'b0;
      instr_q  <= '0;
      inst_vld <= 1'b0;
    end else begin
      st_q     <= st_d;
      strobe_q <= strobe_d;
      abort    <= abort_d;
      halted   <= halted_d;
      instr_q  <= instr_d;
      inst_vld <= inst_vld_d;
    end
  end

  assign sel_pc  = strobe_q.sel_pc;
  assign mem_rd  = strobe_q.mem_rd;
  assign ld_inst = strobe_q.ld_inst;
  assign ld_inc  = strobe_q.ld_inc;
  assign ld_pc   = strobe_q.ld_pc;

endmodule
